// File: rtl/csa_accumulator_pkg.sv
// Shared definitions for the carry-select accumulator.
//   state_e   : controller state, IDLE=0, ACC=1, HOLD=2
//   WIDTH_DEF : operand width (must match the 16-bit CSA adder)
//   CNT_W_DEF : default width of the carry/operand counters
package csa_accumulator_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/CSA.sv
// 16-bit carry-select adder built from 4-bit blocks. Each upper block precomputes its sum for
// carry-in 0 and 1; the incoming block carry selects between them.
//   a, b : addends
//   sum  : low 16 bits of a + b
//   Cout : carry out of bit 15
module CSA (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        Cout,
  output logic [15:0] sum
);

  logic [4:0] blk_c;

  assign blk_c[0] = 1'b0;

  for (genvar g = 0; g < 4; g++) begin : g_blk
    logic [4:0] s0;
    logic [4:0] s1;
    assign s0 = {1'b0, a[4*g+3:4*g]} + {1'b0, b[4*g+3:4*g]};
    assign s1 = {1'b0, a[4*g+3:4*g]} + {1'b0, b[4*g+3:4*g]} + 5'd1;
    assign sum[4*g+3:4*g] = blk_c[g] ? s1[3:0] : s0[3:0];
    assign blk_c[g+1]     = blk_c[g] ? s1[4]   : s0[4];
  end

  assign Cout = blk_c[4];

endmodule

// File: rtl/csa_accumulator_sat_counter.sv
// Saturating counter with sticky overflow flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart; count loads inc (0 or 1) and ovf clears
//   inc        : increment by one, stopping at all-ones
//   count      : current value
//   ovf        : set when an increment was attempted at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MaxVal = '1;

  logic [CNT_W-1:0] count_next;
  logic             ovf_next;

  always_comb begin
    count_next = count;
    ovf_next   = ovf;
    if (clr) begin
      count_next = inc ? CNT_W'(1) : '0;
      ovf_next   = 1'b0;
    end else if (inc) begin
      if (count == MaxVal) begin
        ovf_next = 1'b1;
      end else begin
        count_next = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      count <= count_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: rtl/csa_accumulator.sv
// Packet accumulator around the 16-bit CSA adder. Operand beats arrive on a valid/ready input
// terminated by in_last; the packet total, carry-out count and operand count are held on a
// valid/ready output until consumed.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : operand handshake; in_data operand, in_last ends packet
//   out_valid/out_ready        : result handshake
//   out_sum                    : low WIDTH bits of packet total
//   out_carry                  : CSA carry-outs over the packet (saturating)
//   out_count                  : operands in the packet (saturating)
//   out_ovf                    : either counter saturated
module csa_accumulator
  import csa_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,  // only 16 is supported (fixed CSA width)
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0] out_carry,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  state_e           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic             live;  // low in reset and for the cycle of release, keeps in_ready low
  logic             beat;
  logic [WIDTH-1:0] csa_a, csa_sum;
  logic             csa_cout;
  logic             cnt_clr, carry_inc, count_inc;
  logic             carry_ovf, count_ovf;

  assign in_ready = live && (state != HOLD);
  assign beat     = in_valid && in_ready;
  assign csa_a    = (state == IDLE) ? '0 : acc;

  CSA u_csa (
    .a    (csa_a),
    .b    (in_data),
    .Cout (csa_cout),
    .sum  (csa_sum)
  );

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_clr    = 1'b0;
    carry_inc  = 1'b0;
    count_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (beat) begin
          acc_next   = in_data;
          cnt_clr    = 1'b1;
          count_inc  = 1'b1;
          state_next = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_next  = csa_sum;
          carry_inc = csa_cout;
          count_inc = 1'b1;
          if (in_last) state_next = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          cnt_clr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      live  <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      live  <= 1'b1;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_carry_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (carry_inc),
    .count (out_carry),
    .ovf   (carry_ovf)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_op_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (count_inc),
    .count (out_count),
    .ovf   (count_ovf)
  );

  assign out_valid = (state == HOLD);
  assign out_sum   = acc;
  assign out_ovf   = carry_ovf | count_ovf;

endmodule

// File: tb/tb_csa_accumulator.sv
module tb_csa_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready8, out_valid8, out_ovf8;
  logic [15:0] out_sum8;
  logic [7:0]  out_carry8, out_count8;
  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_sum2;
  logic [1:0]  out_carry2, out_count2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  csa_accumulator #(.WIDTH(16), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_ready(out_ready), .out_sum(out_sum8),
    .out_carry(out_carry8), .out_count(out_count8), .out_ovf(out_ovf8)
  );

  csa_accumulator #(.WIDTH(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_carry(out_carry2), .out_count(out_count2), .out_ovf(out_ovf2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sat(input logic [63:0] v, input int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: packet total as a plain wide integer sum.
  logic        m_live = 1'b0;
  logic        m_hold = 1'b0;
  logic [63:0] m_total = 64'd0;
  logic [63:0] m_n = 64'd0;
  logic [63:0] e_total = 64'd0;
  logic [63:0] e_n = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live  <= 1'b0;
      m_hold  <= 1'b0;
      m_total <= 64'd0;
      m_n     <= 64'd0;
    end else begin
      m_live <= 1'b1;
      if (m_hold) begin
        if (out_ready) m_hold <= 1'b0;
      end else if (m_live && in_valid) begin
        if (in_last) begin
          e_total <= m_total + {48'd0, in_data};
          e_n     <= m_n + 64'd1;
          m_total <= 64'd0;
          m_n     <= 64'd0;
          m_hold  <= 1'b1;
        end else begin
          m_total <= m_total + {48'd0, in_data};
          m_n     <= m_n + 64'd1;
        end
      end
    end
  end

  // Every cycle after reset release: compare both DUTs against the model.
  always @(negedge clk) begin
    if (rst_n && m_live) begin
      chk("in_ready8", {63'd0, in_ready8}, {63'd0, !m_hold});
      chk("in_ready2", {63'd0, in_ready2}, {63'd0, !m_hold});
      chk("out_valid8", {63'd0, out_valid8}, {63'd0, m_hold});
      chk("out_valid2", {63'd0, out_valid2}, {63'd0, m_hold});
      if (m_hold) begin
        chk("m_sum8", {48'd0, out_sum8}, {48'd0, e_total[15:0]});
        chk("m_carry8", {56'd0, out_carry8}, sat(e_total >> 16, 8));
        chk("m_count8", {56'd0, out_count8}, sat(e_n, 8));
        chk("m_ovf8", {63'd0, out_ovf8},
            {63'd0, ((e_total >> 16) > 64'd255) || (e_n > 64'd255)});
        chk("m_sum2", {48'd0, out_sum2}, {48'd0, e_total[15:0]});
        chk("m_carry2", {62'd0, out_carry2}, sat(e_total >> 16, 2));
        chk("m_count2", {62'd0, out_count2}, sat(e_n, 2));
        chk("m_ovf2", {63'd0, out_ovf2},
            {63'd0, ((e_total >> 16) > 64'd3) || (e_n > 64'd3)});
      end
    end
  end

  // Drivers act at posedge+1; tasks return at posedge+1 unless noted.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready8) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'($urandom);
  endtask

  // Returns at a negedge with out_valid8 high (or after the budget expires).
  task automatic get_result(output int waited);
    waited = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid8) break;
      waited++;
    end
    if (waited >= 50) chk("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic release_result();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic lit8(input string n, input logic [15:0] s, input logic [7:0] c,
                      input logic [7:0] k, input logic o);
    chk({n, "_sum"}, {48'd0, out_sum8}, {48'd0, s});
    chk({n, "_carry"}, {56'd0, out_carry8}, {56'd0, c});
    chk({n, "_count"}, {56'd0, out_count8}, {56'd0, k});
    chk({n, "_ovf"}, {63'd0, out_ovf8}, {63'd0, o});
  endtask

  initial begin
    int w;
    int nb;
    logic [15:0] held;

    // Reset state
    #3;
    chk("rst_in_ready", {63'd0, in_ready8}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("rst_sum", {48'd0, out_sum8}, 64'd0);
    chk("rst_count", {56'd0, out_count8}, 64'd0);
    chk("rst_ovf", {63'd0, out_ovf8}, 64'd0);
    #14;
    rst_n = 1'b1;
    idle(2);

    // 1: single beat, out_ready already high
    out_ready = 1'b1;
    idle(2);
    send(16'hF000, 1'b1);
    get_result(w);
    chk("t1_latency", 64'(w), 64'd0);
    lit8("t1", 16'hF000, 8'd0, 8'd1, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idle(1);

    // 2: two all-ones beats
    send(16'hFFFF, 1'b0);
    send(16'hFFFF, 1'b1);
    get_result(w);
    lit8("t2", 16'hFFFE, 8'd1, 8'd2, 1'b0);
    release_result();

    // 3: gapped beats
    send(16'hF0F0, 1'b0);
    idle(2);
    send(16'hF0F0, 1'b0);
    idle(2);
    send(16'h0010, 1'b1);
    get_result(w);
    lit8("t3", 16'hE1F0, 8'd1, 8'd3, 1'b0);
    release_result();

    // 4: backpressure with pending input
    send(16'hAAAA, 1'b1);
    get_result(w);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", {63'd0, in_ready8}, 64'd0);
      chk("t4_hold_valid", {63'd0, out_valid8}, 64'd1);
      chk("t4_hold_sum", {48'd0, out_sum8}, 64'hAAAA);
    end
    release_result();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    get_result(w);
    chk("t4_latency", 64'(w), 64'd0);
    lit8("t4", 16'h1234, 8'd0, 8'd1, 1'b0);
    release_result();

    // 5: saturation
    for (int i = 0; i < 5; i++) send(16'hFFFF, i == 4);
    get_result(w);
    lit8("t5_w8", 16'hFFFB, 8'd4, 8'd5, 1'b0);
    chk("t5_sum2", {48'd0, out_sum2}, 64'hFFFB);
    chk("t5_carry2", {62'd0, out_carry2}, 64'd3);
    chk("t5_count2", {62'd0, out_count2}, 64'd3);
    chk("t5_ovf2", {63'd0, out_ovf2}, 64'd1);
    release_result();

    // 6: reset mid-packet
    send(16'h0005, 1'b0);
    send(16'h0007, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid", {63'd0, out_valid8}, 64'd0);
    chk("t6_in_ready", {63'd0, in_ready8}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    send(16'h0001, 1'b1);
    get_result(w);
    lit8("t6", 16'h0001, 8'd0, 8'd1, 1'b0);
    release_result();

    // Random packets, checked by the model
    for (int p = 0; p < 40; p++) begin
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        held = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom);
        send(held, i == nb - 1);
        idle($urandom_range(0, 2));
      end
      get_result(w);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_result();
      if ($urandom_range(0, 1) == 1) begin
        out_ready = 1'b1;
        idle(2);
        out_ready = 1'b0;
      end
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Sequential front/back stage wrapped around the existing 16-bit carry-select adder `CSA`, with ports (a, b, Cout, sum).
- Accepts a stream of operands on a valid/ready input, terminated by a last flag.
- Accumulates them through one `CSA` instance into a registered running sum, and counts carry-outs and operands.
- Presents the packet total on a valid/ready output that holds until consumed.

Parameters:
- WIDTH, 16, operand/sum width. Must equal the `CSA` width; only 16 is supported.
- CNT_W, 8, width of the carry counter and operand counter. Both counters saturate.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_data  input  WIDTH  operand
- in_last  input  1  final operand of packet, qualified by in_valid
- in_ready  output  1  block can accept a beat
- out_valid  output  1  packet result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  WIDTH  low WIDTH bits of packet total
- out_carry  output  CNT_W  number of `CSA` carry-outs over the packet
- out_count  output  CNT_W  operands accepted in the packet
- out_ovf  output  1  out_carry or out_count saturated

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; acc, carry count, op count, out_valid and out_ovf all 0. in_ready is 0 while rst_n is low and 1 from the first cycle after release.
- Reset mid-packet discards the partial packet. There is no recovery of it.
- Accept condition: beat = in_valid && in_ready, sampled on the rising clk edge. in_data and in_last are ignored when beat is 0.
- `CSA` inputs: a = acc, b = in_data. In IDLE, a is forced to 0.
- States:
  - IDLE:
    - in_ready=1, out_valid=0.
    - On beat: acc<=in_data, carry<=0, count<=1.
    - Next state is HOLD if in_last, else ACC.
  - ACC:
    - in_ready=1, out_valid=0.
    - On beat: acc<=`CSA`.sum, carry<=carry+`CSA`.Cout, count<=count+1.
    - Goes to HOLD if in_last. Otherwise stays in ACC; with no beat, stays in ACC and holds all values.
  - HOLD:
    - in_ready=0, out_valid=1.
    - out_sum=acc, out_carry=carry, out_count=count.
    - On out_ready: go to IDLE and clear acc, carry and count. out_valid drops in the next cycle.
    - No input beat is accepted in the handshake cycle (one bubble per packet).
- Latency: out_valid asserts in the cycle after the beat carrying in_last.
- Saturation:
  - carry and count stop at 2^CNT_W-1.
  - out_ovf sets when an increment would exceed the maximum, and clears on IDLE entry.
- Non-saturated total equals {out_carry, out_sum} = sum of all operands, exact.
- Outputs are registered and stable while out_valid && !out_ready.
- A held out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package:
  - state enum {IDLE, ACC, HOLD}, 2-bit encoding IDLE=0, ACC=1, HOLD=2.
  - Constants WIDTH_DEF=16 and CNT_W_DEF=8.
- Sub-modules:
  - One instance of the existing `CSA` adder; no re-implementation of addition.
  - A sub-module `sat_counter` (CNT_W, inc, clr, ovf) is natural and is used twice.

Test Plan:
1. Single-beat packet:
   - Stimulus: in_data=0xF000, in_last=1, out_ready=1.
   - Required: next cycle out_valid=1, out_sum=0xF000, out_carry=0, out_count=1, out_ovf=0.
2. Two beats 0xFFFF, 0xFFFF (last on 2nd):
   - Required: out_sum=0xFFFE, out_carry=1, out_count=2.
3. Three beats 0xF0F0, 0xF0F0, 0x0010, with in_valid gapped 2 idle cycles between beats:
   - Required: out_sum=0xE1F0, out_carry=1, out_count=3.
4. Backpressure:
   - Stimulus: after result, out_ready=0 for 5 cycles while in_valid=1 with 0x1234.
   - Required: outputs constant, in_ready=0. After out_ready=1, the next packet 0x1234 (last) yields out_sum=0x1234 and out_carry=0, with no residue from the previous packet.
5. Saturation, CNT_W=2:
   - Stimulus: five beats of 0xFFFF.
   - Required: out_sum=0xFFFB, out_carry=3, out_count=3, out_ovf=1.
6. Reset mid-packet:
   - Stimulus: two beats accepted, then rst_n=0 asynchronously for 1 cycle.
   - Required: immediately out_valid=0. Single beat 0x0001 (last) then gives out_sum=0x0001, out_count=1.
